// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//  Shared types and constants for the UART transmit path.
//  feeder_state_t : launch FSM states used by uart_tx_feeder
//  UART_DATA_W    : byte width; matches the transmitter's TxData width
//  UART_FIFO_DEPTH: default feeder FIFO depth
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } feeder_state_t;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//  Single-clock byte FIFO with occupancy count and a drop indicator.
//  Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en, wr_data    push request and data (ignored when full)
//   rd_en             pop request (ignored when empty)
//   rd_data           head entry, valid whenever empty=0
//   full, empty       occupancy flags, registered
//   count             entries held
//   overflow          1-cycle pulse after a write was dropped
//  DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;
    logic              push_s;
    logic              pop_s;

    // Qualify requests and compute the next occupancy.
    always_comb begin
        push_s      = wr_en && !full_r;
        pop_s       = rd_en && !empty_r;
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pointers, count and flags; flags are derived from the next count so they stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r    <= (count_nxt_s == CNT_W'(0));
            // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
            overflow_r <= wr_en && full_r;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//  Byte FIFO plus launch FSM upstream of the UART transmitter. Bytes are
//  queued from the host side and launched one frame at a time over the
//  transmit/TxData/busy handshake (carried by uart_if at integration).
//  Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en, wr_data    host push
//   full, empty       FIFO occupancy flags
//   count             bytes queued, not counting the byte being sent
//   overflow          1-cycle pulse after a dropped write
//   transmit, TxData  registered launch request and byte to the transmitter
//   busy              transmitter frame in progress
//   drop_cnt          saturating dropped-write counter (only with
//                     UART_TX_FEEDER_DROPCNT_EN defined)
//  Configuration macro: UART_TX_FEEDER_DROPCNT_EN
// -----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       transmit,
    output logic [DATA_W-1:0]          TxData,
    input  logic                       busy
`ifdef UART_TX_FEEDER_DROPCNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    feeder_state_t     state_r;
    feeder_state_t     state_nxt_s;
    logic              pop_s;
    logic              transmit_nxt_s;
    logic              transmit_r;
    logic [DATA_W-1:0] txdata_r;
    logic [DATA_W-1:0] head_s;
    logic              fifo_empty_s;
    logic              fifo_overflow_s;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .full     (full),
        .empty    (fifo_empty_s),
        .count    (count),
        .overflow (fifo_overflow_s)
    );

    // Launch FSM: next state, pop strobe and next transmit level.
    always_comb begin
        state_nxt_s    = state_r;
        pop_s          = 1'b0;
        transmit_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                // empty is registered, so a byte pushed this cycle is popped next cycle.
                if (!fifo_empty_s && !busy) begin
                    pop_s          = 1'b1;
                    transmit_nxt_s = 1'b1;
                    state_nxt_s    = LAUNCH;
                end else begin
                    transmit_nxt_s = 1'b0;
                    state_nxt_s    = IDLE;
                end
            end
            LAUNCH: begin
                // Drop transmit on the edge busy is first seen so the request cannot retrigger.
                if (busy) begin
                    transmit_nxt_s = 1'b0;
                    state_nxt_s    = WAIT_DONE;
                end else begin
                    transmit_nxt_s = 1'b1;
                    state_nxt_s    = LAUNCH;
                end
            end
            WAIT_DONE: begin
                transmit_nxt_s = 1'b0;
                if (!busy) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                transmit_nxt_s = 1'b0;
                state_nxt_s    = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered launch outputs; TxData is captured only at pop and held through the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            transmit_r <= 1'b0;
            txdata_r   <= DATA_W'(0);
        end else begin
            transmit_r <= transmit_nxt_s;
            if (pop_s) begin
                txdata_r <= head_s;
            end
        end
    end

    assign transmit = transmit_r;
    assign TxData   = txdata_r;
    assign empty    = fifo_empty_s;
    assign overflow = fifo_overflow_s;

`ifdef UART_TX_FEEDER_DROPCNT_EN
    logic [15:0] drop_cnt_r;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    // Dropped-write counter, stepped by the overflow pulse and held at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_r <= 16'd0;
        end else if (fifo_overflow_s) begin
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int CPB   = 8;      // transmitter clocks per bit, kept short for run time
    localparam int FRAME = CPB * 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       transmit;
    logic [7:0] TxData;
    logic       busy;
    logic       busy_tx;
    logic       busy_force;
    logic       txd;
`ifdef UART_TX_FEEDER_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    assign busy = busy_tx | busy_force;

    uart_tx_feeder dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .transmit (transmit),
        .TxData   (TxData),
        .busy     (busy)
`ifdef UART_TX_FEEDER_DROPCNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- transmitter model: 8N1 on txd, busy for one frame ----------------
    initial begin
        logic [9:0] frame;
        busy_tx = 1'b0;
        txd     = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (transmit && !busy_tx) begin
                frame   = {1'b1, TxData, 1'b0};
                busy_tx = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    txd = frame[i];
                    repeat (CPB) @(posedge clk);
                end
                #1;
                txd     = 1'b1;
                busy_tx = 1'b0;
            end
        end
    end

    // ---------------- serial receiver: decodes txd into rx_q ----------------
    logic [7:0] rx_q[$];
    int         frame_err = 0;

    initial begin
        logic [7:0] b;
        logic       bad;
        forever begin
            @(negedge txd);
            repeat (CPB / 2) @(posedge clk);
            bad = (txd !== 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                b[i] = txd;
            end
            repeat (CPB) @(posedge clk);
            if (txd !== 1'b1) bad = 1'b1;
            if (bad) frame_err++;
            rx_q.push_back(b);
        end
    end

    // ---------------- handshake monitor ----------------
    int   cyc = 0;
    int   dut_launches = 0;
    int   retrig = 0;
    int   last_fall = 0;
    int   max_gap = 0;
    logic gap_en = 1'b0;
    logic prev_tx = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_txbusy = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (transmit && !prev_tx) begin
            dut_launches <= dut_launches + 1;
            if (gap_en && (cyc - last_fall > max_gap)) max_gap <= cyc - last_fall;
        end
        if (!gap_en) max_gap <= 0;
        if (!busy && prev_busy) last_fall <= cyc;
        if (transmit && busy && prev_txbusy) retrig <= retrig + 1;
        prev_tx     <= transmit;
        prev_busy   <= busy;
        prev_txbusy <= transmit && busy;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int         model_occ = 0;   // occupancy while launches are held off
    logic       expect_ovf;
    int         rx_base = 0;

    task automatic model_push(input logic [7:0] d);
        if (model_occ < DEPTH) begin
            exp_q.push_back(d);
            model_occ++;
            expect_ovf = 1'b0;
        end else begin
            expect_ovf = 1'b1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input string tag);
        int k = 0;
        while (rx_q.size() < rx_base + exp_q.size() && k < (exp_q.size() + 2) * (FRAME + 20)) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq({tag, "_frames"}, rx_q.size() - rx_base, exp_q.size());
    endtask

    task automatic compare_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (rx_base + i < rx_q.size())
                check_eq($sformatf("%s_byte%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
        end
        rx_base   = rx_q.size();
        exp_q     = {};
        model_occ = 0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy_tx || !empty || transmit) && k < 40 * FRAME) begin
            tick(1);
            k++;
        end
        check_eq("idle_reached", k < 40 * FRAME, 1);
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int launches_before;
        int k;
        logic [7:0] r;
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        busy_force = 1'b0;
        expect_ovf = 1'b0;
        tick(3);
        check_eq("rst_full", full, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_count", count, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_transmit", transmit, 0);
        check_eq("rst_txdata", TxData, 0);
        reset = 1'b0;
        tick(2);

        // 1: single byte, latency and framing
        push(8'hA5);
        exp_q.push_back(8'hA5);
        check_eq("t1_count1", count, 1);
        check_eq("t1_no_bypass", transmit, 0);
        tick(1);
        check_eq("t1_transmit", transmit, 1);
        check_eq("t1_txdata", TxData, 8'hA5);
        check_eq("t1_empty_after_pop", empty, 1);
        wait_rx("t1");
        compare_stream("t1");
        wait_idle();

        // 2: burst of 16, fill, in-order drain with short gaps
        busy_force = 1'b1;
        for (int i = 1; i <= 16; i++) model_push(8'(i));
        for (int i = 1; i <= 16; i++) push(8'(i));
        check_eq("t2_full", full, 1);
        check_eq("t2_count", count, model_occ);
        busy_force = 1'b0;
        gap_en     = 1'b1;
        wait_rx("t2");
        gap_en     = 1'b0;
        check_eq("t2_gap_le2", max_gap <= 2, 1);
        compare_stream("t2");
        wait_idle();

        // 3: 17 writes while held idle -> one drop
        busy_force = 1'b1;
        for (int i = 0; i < 17; i++) begin
            r = 8'(8'h40 + i);
            model_push(r);
            push(r);
        end
        check_eq("t3_overflow", overflow, expect_ovf);
        check_eq("t3_count", count, model_occ);
        tick(1);
        check_eq("t3_overflow_pulse", overflow, 0);
`ifdef UART_TX_FEEDER_DROPCNT_EN
        check_eq("t3_drop_cnt", drop_cnt, 1);
`endif
        busy_force = 1'b0;
        wait_rx("t3");
        compare_stream("t3");
        wait_idle();

        // 4: push+pop in the same cycle at count 5, then pointer wrap over 40 bytes
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r = 8'($urandom);
            model_push(r);
            push(r);
        end
        check_eq("t4_count5", count, model_occ);
        r = 8'($urandom);
        exp_q.push_back(r);
        wr_en      = 1'b1;
        wr_data    = r;
        busy_force = 1'b0;
        tick(1);
        wr_en = 1'b0;
        check_eq("t4_count_hold", count, 5);
        check_eq("t4_launch", transmit, 1);
        for (int i = 0; i < 34; i++) begin
            k = 0;
            while (full && k < 4 * FRAME) begin
                tick(1);
                k++;
            end
            r = 8'($urandom);
            exp_q.push_back(r);
            push(r);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, FRAME));
        end
        wait_rx("t4");
        compare_stream("t4");
        wait_idle();

        // 5: reset in the middle of a frame with 4 queued
        push(8'h3C);
        for (int i = 1; i <= 4; i++) push(8'(8'h50 + i));
        exp_q.push_back(8'h3C);
        tick(3 * CPB);
        check_eq("t5_busy", busy_tx, 1);
        check_eq("t5_count4", count, 4);
        launches_before = dut_launches;
        reset = 1'b1;
        tick(1);
        check_eq("t5_rst_full", full, 0);
        check_eq("t5_rst_empty", empty, 1);
        check_eq("t5_rst_count", count, 0);
        check_eq("t5_rst_transmit", transmit, 0);
        check_eq("t5_rst_txdata", TxData, 0);
`ifdef UART_TX_FEEDER_DROPCNT_EN
        check_eq("t5_rst_drop_cnt", drop_cnt, 0);
`endif
        reset = 1'b0;
        tick(3 * FRAME);
        check_eq("t5_no_launch", dut_launches, launches_before);
        wait_rx("t5");
        compare_stream("t5");
        push(8'h77);
        exp_q.push_back(8'h77);
        wait_rx("t5_after");
        compare_stream("t5_after");
        wait_idle();

        // 6: external busy while idle defers the launch
        launches_before = dut_launches;
        busy_force = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = 8'($urandom);
            model_push(r);
            push(r);
        end
        tick(50);
        check_eq("t6_deferred", dut_launches, launches_before);
        check_eq("t6_count", count, model_occ);
        busy_force = 1'b0;
        wait_rx("t6");
        compare_stream("t6");
        wait_idle();

        check_eq("no_retrigger", retrig, 0);
        check_eq("framing", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
